// File: rtl/rfg_axis_protocol_decoder_pkg.sv
// Shared types and constants for the RFG protocol byte-stream decoder.
// The optional idle timeout is selected with the RFG_PROTOCOL_TIMEOUT_EN macro.
package rfg_axis_protocol_pkg;

  // Decoder states, one per frame field plus the three read-beat phases.
  typedef enum logic [2:0] {
    ST_HEADER   = 3'd0,
    ST_ADDR     = 3'd1,
    ST_LEN_MSB  = 3'd2,
    ST_LEN_LSB  = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_RD_ISSUE = 3'd5,
    ST_RD_WAIT  = 3'd6,
    ST_RD_SEND  = 3'd7
  } rfg_proto_state_t;

  // Header byte layout.
  localparam int          RFG_HDR_READ_BIT  = 7;
  localparam int          RFG_HDR_INCR_BIT  = 6;
  localparam logic [7:0]  RFG_HDR_RSVD_MASK = 8'h3F;

  // A header is accepted only when all reserved bits are zero.
  function automatic logic rfg_hdr_valid(input logic [7:0] hdr);
    return ((hdr & RFG_HDR_RSVD_MASK) == 8'h00);
  endfunction

endpackage

// File: rtl/rfg_axis_protocol_decoder_if.sv
// Byte-wide AXI-Stream link carrying read responses out of the decoder.
interface rfg_axis_protocol_decoder_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rfg_axis_protocol_decoder_timeout.sv
// Mid-frame idle counter for the RFG protocol decoder. Only instantiated
// when RFG_PROTOCOL_TIMEOUT_EN is defined.
module rfg_axis_protocol_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic resn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle busy cycle; it is
  // combinational so the decoder can abort in that same cycle.
  assign o_expire = i_enable && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

  // Idle count: restarts on activity, when idle outside a frame, or after expiry.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_count <= '0;
    end else if (i_clear || !i_enable || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/rfg_axis_protocol_decoder.sv
// RFG protocol byte-stream decoder: pops frames from the protocol FIFO and
// turns them into register-file write/read strobes; read data leaves on an
// AXI-Stream byte master. Optional idle timeout: RFG_PROTOCOL_TIMEOUT_EN.
module rfg_axis_protocol_decoder
  import rfg_axis_protocol_pkg::*;
#(
  parameter int AWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resn,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [7:0]        fifo_read_value,
  output logic [AWIDTH-1:0] rfg_address,
  output logic              rfg_write,
  output logic [7:0]        rfg_write_value,
  output logic              rfg_read,
  input  logic [7:0]        rfg_read_value,
  rfg_axis_protocol_decoder_if.master m_axis,
  output logic              busy,
  output logic              protocol_error
);

  rfg_proto_state_t  r_state,  w_state_n;
  logic              r_is_read, w_is_read_n;
  logic              r_incr,    w_incr_n;
  logic [AWIDTH-1:0] r_addr,    w_addr_n;
  logic [7:0]        r_len_msb, w_len_msb_n;
  logic [16:0]       r_remain,  w_remain_n;

  logic [AWIDTH-1:0] r_rfg_address,     w_rfg_address_n;
  logic              r_rfg_write,       w_rfg_write_n;
  logic [7:0]        r_rfg_write_value, w_rfg_write_value_n;
  logic              r_rfg_read,        w_rfg_read_n;
  logic              r_tvalid,          w_tvalid_n;
  logic [7:0]        r_tdata,           w_tdata_n;
  logic              r_tlast,           w_tlast_n;
  logic              r_busy,            w_busy_n;
  logic              r_error,           w_error_n;

  logic              w_consume_state;
  logic              w_consume;
  logic              w_timeout;
  logic [AWIDTH-1:0] w_addr_step;

  // Pop request: only the byte-consuming states, and only when a byte is present.
  always_comb begin
    case (r_state)
      ST_HEADER, ST_ADDR, ST_LEN_MSB, ST_LEN_LSB, ST_WR_DATA: w_consume_state = 1'b1;
      default:                                               w_consume_state = 1'b0;
    endcase
  end

  assign w_consume = w_consume_state && !fifo_empty;
  assign fifo_read = w_consume;

  // Post-transfer address: wraps naturally at 2^AWIDTH when incrementing.
  assign w_addr_step = r_incr ? (r_addr + AWIDTH'(1)) : r_addr;

`ifdef RFG_PROTOCOL_TIMEOUT_EN
  logic w_idle_clear;

  assign w_idle_clear = w_consume || (r_tvalid && m_axis.tready);

  rfg_axis_protocol_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .resn     (resn),
    .i_clear  (w_idle_clear),
    .i_enable (r_busy),
    .o_expire (w_timeout)
  );
`else
  // No idle counter in this build: a partial frame waits indefinitely.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-output logic for the frame decoder.
  always_comb begin
    w_state_n           = r_state;
    w_is_read_n         = r_is_read;
    w_incr_n            = r_incr;
    w_addr_n            = r_addr;
    w_len_msb_n         = r_len_msb;
    w_remain_n          = r_remain;
    w_rfg_address_n     = r_rfg_address;
    w_rfg_write_n       = 1'b0;
    w_rfg_write_value_n = r_rfg_write_value;
    w_rfg_read_n        = 1'b0;
    w_tvalid_n          = r_tvalid;
    w_tdata_n           = r_tdata;
    w_tlast_n           = r_tlast;
    w_error_n           = 1'b0;

    if (!w_timeout) begin
      case (r_state)
        ST_HEADER: begin
          if (w_consume) begin
            if (rfg_hdr_valid(fifo_read_value)) begin
              w_is_read_n = fifo_read_value[RFG_HDR_READ_BIT];
              w_incr_n    = fifo_read_value[RFG_HDR_INCR_BIT];
              w_state_n   = ST_ADDR;
            end else begin
              // Bad header byte is dropped; the next byte is taken as a header.
              w_error_n   = 1'b1;
            end
          end else begin
            w_state_n = ST_HEADER;
          end
        end

        ST_ADDR: begin
          if (w_consume) begin
            w_addr_n  = AWIDTH'(fifo_read_value);
            w_state_n = ST_LEN_MSB;
          end else begin
            w_state_n = ST_ADDR;
          end
        end

        ST_LEN_MSB: begin
          if (w_consume) begin
            w_len_msb_n = fifo_read_value;
            w_state_n   = ST_LEN_LSB;
          end else begin
            w_state_n = ST_LEN_MSB;
          end
        end

        ST_LEN_LSB: begin
          if (w_consume) begin
            w_remain_n = {1'b0, r_len_msb, fifo_read_value} + 17'd1;
            if (r_is_read) begin
              // Strobe is registered so it is high exactly while in RD_ISSUE.
              w_rfg_read_n    = 1'b1;
              w_rfg_address_n = r_addr;
              w_state_n       = ST_RD_ISSUE;
            end else begin
              w_state_n = ST_WR_DATA;
            end
          end else begin
            w_state_n = ST_LEN_LSB;
          end
        end

        ST_WR_DATA: begin
          if (w_consume) begin
            w_rfg_write_n       = 1'b1;
            w_rfg_address_n     = r_addr;
            w_rfg_write_value_n = fifo_read_value;
            w_addr_n            = w_addr_step;
            w_remain_n          = r_remain - 17'd1;
            w_state_n           = (r_remain == 17'd1) ? ST_HEADER : ST_WR_DATA;
          end else begin
            w_state_n = ST_WR_DATA;
          end
        end

        ST_RD_ISSUE: begin
          w_addr_n   = w_addr_step;
          w_remain_n = r_remain - 17'd1;
          w_state_n  = ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          w_tdata_n  = rfg_read_value;
          w_tvalid_n = 1'b1;
          w_tlast_n  = (r_remain == 17'd0);
          w_state_n  = ST_RD_SEND;
        end

        ST_RD_SEND: begin
          if (r_tvalid && m_axis.tready) begin
            w_tvalid_n = 1'b0;
            w_tlast_n  = 1'b0;
            if (r_remain != 17'd0) begin
              w_rfg_read_n    = 1'b1;
              w_rfg_address_n = r_addr;
              w_state_n       = ST_RD_ISSUE;
            end else begin
              w_state_n = ST_HEADER;
            end
          end else begin
            w_state_n = ST_RD_SEND;
          end
        end

        default: begin
          w_state_n = ST_HEADER;
        end
      endcase
    end else begin
      // Idle expiry aborts the frame and drops any pending response beat.
      w_state_n    = ST_HEADER;
      w_tvalid_n   = 1'b0;
      w_tlast_n    = 1'b0;
      w_rfg_read_n = 1'b0;
      w_rfg_write_n = 1'b0;
      w_error_n    = 1'b1;
    end

    w_busy_n = (w_state_n != ST_HEADER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_state           <= ST_HEADER;
      r_is_read         <= 1'b0;
      r_incr            <= 1'b0;
      r_addr            <= '0;
      r_len_msb         <= 8'h00;
      r_remain          <= 17'd0;
      r_rfg_address     <= '0;
      r_rfg_write       <= 1'b0;
      r_rfg_write_value <= 8'h00;
      r_rfg_read        <= 1'b0;
      r_tvalid          <= 1'b0;
      r_tdata           <= 8'h00;
      r_tlast           <= 1'b0;
      r_busy            <= 1'b0;
      r_error           <= 1'b0;
    end else begin
      r_state           <= w_state_n;
      r_is_read         <= w_is_read_n;
      r_incr            <= w_incr_n;
      r_addr            <= w_addr_n;
      r_len_msb         <= w_len_msb_n;
      r_remain          <= w_remain_n;
      r_rfg_address     <= w_rfg_address_n;
      r_rfg_write       <= w_rfg_write_n;
      r_rfg_write_value <= w_rfg_write_value_n;
      r_rfg_read        <= w_rfg_read_n;
      r_tvalid          <= w_tvalid_n;
      r_tdata           <= w_tdata_n;
      r_tlast           <= w_tlast_n;
      r_busy            <= w_busy_n;
      r_error           <= w_error_n;
    end
  end

  assign rfg_address     = r_rfg_address;
  assign rfg_write       = r_rfg_write;
  assign rfg_write_value = r_rfg_write_value;
  assign rfg_read        = r_rfg_read;
  assign m_axis.tvalid   = r_tvalid;
  assign m_axis.tdata    = r_tdata;
  assign m_axis.tlast    = r_tlast;
  assign busy            = r_busy;
  assign protocol_error  = r_error;

endmodule

// File: tb/tb_rfg_axis_protocol_decoder.sv
// Directed bench for rfg_axis_protocol_decoder: FIFO and register-file models,
// a negedge monitor logging strobes/beats, and hand-computed expectations.
module tb_rfg_axis_protocol_decoder;

  logic       clk = 1'b0;
  logic       resn = 1'b0;
  logic       fifo_empty;
  logic       fifo_read;
  logic [7:0] fifo_read_value;
  logic [7:0] rfg_address;
  logic       rfg_write;
  logic [7:0] rfg_write_value;
  logic       rfg_read;
  logic [7:0] rfg_read_value = 8'h00;
  logic       busy;
  logic       protocol_error;

  rfg_axis_protocol_decoder_if u_axis ();

  rfg_axis_protocol_decoder #(
    .AWIDTH         (8),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk             (clk),
    .resn            (resn),
    .fifo_empty      (fifo_empty),
    .fifo_read       (fifo_read),
    .fifo_read_value (fifo_read_value),
    .rfg_address     (rfg_address),
    .rfg_write       (rfg_write),
    .rfg_write_value (rfg_write_value),
    .rfg_read        (rfg_read),
    .rfg_read_value  (rfg_read_value),
    .m_axis          (u_axis),
    .busy            (busy),
    .protocol_error  (protocol_error)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model
  logic [7:0] fifo_mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty      = (rd_ptr == wr_ptr);
  assign fifo_read_value = fifo_mem[rd_ptr[5:0]];
  always @(posedge clk) if (fifo_read && !fifo_empty) rd_ptr <= rd_ptr + 1;

  // Register file model: returns queued bytes one cycle after each read strobe
  logic [7:0] resp_mem [0:15];
  int         resp_idx = 0;
  always @(posedge clk) begin
    if (rfg_read) begin
      rfg_read_value <= resp_mem[resp_idx[3:0]];
      resp_idx       <= resp_idx + 1;
    end
  end

  // Monitor logs
  int         cyc = 0;
  int         wr_cnt = 0, rd_cnt = 0, beat_cnt = 0, err_cnt = 0;
  int         both_cnt = 0, pop_empty_cnt = 0;
  logic [7:0] wr_addr [0:31];
  logic [7:0] wr_data [0:31];
  logic       wr_busy [0:31];
  int         wr_cyc  [0:31];
  logic [7:0] rd_addr [0:31];
  int         rd_cyc  [0:31];
  logic [7:0] bt_data [0:31];
  logic       bt_last [0:31];
  int         bt_cyc  [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rfg_write && wr_cnt < 32) begin
      wr_addr[wr_cnt] <= rfg_address;
      wr_data[wr_cnt] <= rfg_write_value;
      wr_busy[wr_cnt] <= busy;
      wr_cyc[wr_cnt]  <= cyc;
    end
    if (rfg_write) wr_cnt <= wr_cnt + 1;
    if (rfg_read && rd_cnt < 32) begin
      rd_addr[rd_cnt] <= rfg_address;
      rd_cyc[rd_cnt]  <= cyc;
    end
    if (rfg_read) rd_cnt <= rd_cnt + 1;
    if (u_axis.tvalid && u_axis.tready && beat_cnt < 32) begin
      bt_data[beat_cnt] <= u_axis.tdata;
      bt_last[beat_cnt] <= u_axis.tlast;
      bt_cyc[beat_cnt]  <= cyc;
    end
    if (u_axis.tvalid && u_axis.tready) beat_cnt <= beat_cnt + 1;
    if (protocol_error) err_cnt <= err_cnt + 1;
    if (rfg_read && rfg_write) both_cnt <= both_cnt + 1;
    if (fifo_read && fifo_empty) pop_empty_cnt <= pop_empty_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, fifo_read, rfg_write, rfg_read, busy, protocol_error,
                          u_axis.tvalid, u_axis.tlast}, 32'd0);
    check({tag, "_data"}, {8'd0, rfg_address, rfg_write_value, u_axis.tdata}, 32'd0);
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wb, rb, bb, eb, held_ok;
    resp_mem[0] = 8'h5A; resp_mem[1] = 8'h6B; resp_mem[2] = 8'h11;
    resp_mem[3] = 8'h22; resp_mem[4] = 8'h9C;
    u_axis.tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 resn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Incrementing write frame, three bytes
    wb = wr_cnt;
    push(8'h40); push(8'h10); push(8'h00); push(8'h02);
    push(8'hAA); push(8'hBB); push(8'hCC);
    for (int i = 0; i < 100 && wr_cnt < wb + 3; i++) @(posedge clk);
    @(negedge clk);
    check("wr_count", wr_cnt - wb, 3);
    check("wr0", {wr_addr[wb], wr_data[wb]}, 16'h10AA);
    check("wr1", {wr_addr[wb+1], wr_data[wb+1]}, 16'h11BB);
    check("wr2", {wr_addr[wb+2], wr_data[wb+2]}, 16'h12CC);
    check("wr_b2b", {wr_cyc[wb+1] - wr_cyc[wb], wr_cyc[wb+2] - wr_cyc[wb+1]}, {32'd1, 32'd1});
    check("wr_busy_first", wr_busy[wb], 1'b1);
    check("wr_busy_last", wr_busy[wb+2], 1'b0);

    // Fixed-address read frame, two transfers
    @(posedge clk); #1;
    rb = rd_cnt; bb = beat_cnt;
    push(8'h80); push(8'h20); push(8'h00); push(8'h01);
    for (int i = 0; i < 100 && beat_cnt < bb + 2; i++) @(posedge clk);
    @(negedge clk);
    check("rd_count", rd_cnt - rb, 2);
    check("rd_addr", {rd_addr[rb], rd_addr[rb+1]}, 16'h2020);
    check("beat0", {bt_data[bb], 7'd0, bt_last[bb]}, 16'h5A00);
    check("beat1", {bt_data[bb+1], 7'd0, bt_last[bb+1]}, 16'h6B01);
    check("rd_latency", bt_cyc[bb] - rd_cyc[rb], 2);
    check("rd_interval", bt_cyc[bb+1] - bt_cyc[bb], 3);
    check("rd_busy_end", busy, 1'b0);

    // Incrementing read wrapping 0xFF -> 0x00
    @(posedge clk); #1;
    rb = rd_cnt; bb = beat_cnt;
    push(8'hC0); push(8'hFF); push(8'h00); push(8'h01);
    for (int i = 0; i < 100 && beat_cnt < bb + 2; i++) @(posedge clk);
    @(negedge clk);
    check("wrap_addr", {rd_addr[rb], rd_addr[rb+1]}, 16'hFF00);
    check("wrap_beats", {bt_data[bb], bt_data[bb+1], 7'd0, bt_last[bb+1]}, 24'h112201);

    // Bad header followed by a valid single-byte write
    @(posedge clk); #1;
    wb = wr_cnt; rb = rd_cnt; eb = err_cnt;
    push(8'h81); push(8'h00); push(8'h05); push(8'h00); push(8'h00); push(8'h77);
    for (int i = 0; i < 100 && wr_cnt < wb + 1; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    check("bad_hdr_err", err_cnt - eb, 1);
    check("bad_hdr_reads", rd_cnt - rb, 0);
    check("bad_hdr_writes", wr_cnt - wb, 1);
    check("after_bad_wr", {wr_addr[wb], wr_data[wb]}, 16'h0577);

    // Read with tready held low: beat must hold, no further read strobes
    @(posedge clk); #1;
    u_axis.tready = 1'b0;
    bb = beat_cnt;
    push(8'h80); push(8'h30); push(8'h00); push(8'h00);
    for (int i = 0; i < 100 && !u_axis.tvalid; i++) @(negedge clk);
    check("stall_valid", u_axis.tvalid, 1'b1);
    rb = rd_cnt;
    held_ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_axis.tvalid && u_axis.tdata == 8'h9C && u_axis.tlast && rd_cnt == rb) held_ok++;
    end
    check("stall_held", held_ok, 10);
    @(posedge clk); #1 u_axis.tready = 1'b1;
    for (int i = 0; i < 50 && beat_cnt < bb + 1; i++) @(posedge clk);
    @(negedge clk);
    check("stall_beat", {bt_data[bb], 7'd0, bt_last[bb]}, 16'h9C01);
    check("stall_done", {u_axis.tvalid, busy}, 2'b00);

    // Reset asserted mid-write: no strobe, outputs cleared
    @(posedge clk); #1;
    wb = wr_cnt;
    push(8'h00); push(8'h50); push(8'h00); push(8'h01);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("midwr_busy", busy, 1'b1);
    #1 resn = 1'b0;
    @(negedge clk);
    check_all_zero("midwr_reset");
    repeat (2) @(posedge clk); #1 resn = 1'b1;
    repeat (4) @(negedge clk);
    check("midwr_no_write", wr_cnt - wb, 0);
    check("midwr_idle", busy, 1'b0);
    @(posedge clk); #1;
    push(8'h00); push(8'h60); push(8'h00); push(8'h00); push(8'h33);
    for (int i = 0; i < 100 && wr_cnt < wb + 1; i++) @(posedge clk);
    @(negedge clk);
    check("post_reset_wr", {wr_addr[wb], wr_data[wb]}, 16'h6033);

`ifdef RFG_PROTOCOL_TIMEOUT_EN
    // Frame stops after the address byte: idle expiry returns to HEADER
    @(posedge clk); #1;
    eb = err_cnt; wb = wr_cnt;
    push(8'h40); push(8'h70);
    for (int i = 0; i < 60 && err_cnt < eb + 1; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    check("timeout_err", err_cnt - eb, 1);
    check("timeout_idle", busy, 1'b0);
    @(posedge clk); #1;
    push(8'h00); push(8'h71); push(8'h00); push(8'h00); push(8'h44);
    for (int i = 0; i < 100 && wr_cnt < wb + 1; i++) @(posedge clk);
    @(negedge clk);
    check("after_timeout_wr", {wr_addr[wb], wr_data[wb]}, 16'h7144);
`endif

    check("rd_wr_overlap", both_cnt, 0);
    check("pop_when_empty", pop_empty_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rfg_axis_protocol_decoder.md
# rfg_axis_protocol_decoder

Byte-stream command decoder for the register-file generator (RFG) protocol path. It sits directly downstream of the protocol byte FIFO: it pops header, address, length and payload bytes and turns each frame into register-file write strobes or read strobes. Read results are returned on an AXI-Stream byte master towards the response path.

## Interface
- `AWIDTH`, default 8: register address width; the address byte supplies the low 8 bits, and upper bits are zero.
- `TIMEOUT_CYCLES`, default 1024: idle cycles allowed mid-frame. Used only with `RFG_PROTOCOL_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `resn` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: upstream FIFO empty.
- `fifo_read` out 1: pop request; combinational, only asserted while `!fifo_empty`.
- `fifo_read_value` in 8: FIFO head byte, valid in the same cycle.
- `rfg_address` out AWIDTH: register address.
- `rfg_write` out 1: one-cycle write strobe.
- `rfg_write_value` out 8: write data.
- `rfg_read` out 1: one-cycle read strobe.
- `rfg_read_value` in 8: register data, valid exactly 1 cycle after `rfg_read`.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out 8, `m_axis_tlast` out 1: read-response stream.
- `busy` out 1: high whenever state ≠ HEADER.
- `protocol_error` out 1: one-cycle pulse on a bad header or timeout.

## Operation
- Frame format:
  - Header byte: [7] = read (1) / write (0); [6] = address auto-increment; [5:0] must be 0.
  - Address byte.
  - Length MSB byte, then length LSB byte. Transfer count N = length + 1, range 1..65536.
  - Write frames then carry N data bytes. Read frames carry no payload.
- A byte is consumed in any cycle where `fifo_read && !fifo_empty`. `fifo_read` is asserted only in the HEADER, ADDR, LEN_MSB, LEN_LSB and WR_DATA states.
- State machine:
  - HEADER → ADDR when the header is valid. A header with nonzero [5:0] is dropped: pulse `protocol_error`, stay in HEADER.
  - ADDR → LEN_MSB → LEN_LSB.
  - LEN_LSB → WR_DATA (write) or RD_ISSUE (read).
  - WR_DATA: each consumed byte produces one `rfg_write`. After N bytes → HEADER.
  - RD_ISSUE: assert `rfg_read` → RD_WAIT.
  - RD_WAIT: capture `rfg_read_value` into the output register and set `m_axis_tvalid` → RD_SEND.
  - RD_SEND: on `m_axis_tvalid && m_axis_tready`, go to RD_ISSUE if transfers remain, else HEADER.
- Address: when the increment bit is set, the address advances by 1 after each transfer and wraps modulo 2^AWIDTH (0xFF → 0x00 at the default width). With the bit clear, the address is fixed.
- Remaining-count counter is 17 bits, loaded with length + 1, decremented per transfer.
- `m_axis_tlast` = 1 on the final byte of a read frame. `tdata`, `tlast` and `tvalid` stay stable until accepted.
- Reset values: all outputs 0, state HEADER, counters 0. Reset mid-frame discards the frame and any pending response beat with no strobe emitted. Bytes already popped are lost; the FIFO is reset by the same `resn`.

## Timing
- `rfg_write`, `rfg_address` and `rfg_write_value` are registered: they appear 1 cycle after the data byte is consumed. Back-to-back bytes give back-to-back write strobes at 1 byte/cycle.
- Read throughput:
  - The first beat appears 2 cycles after entering RD_ISSUE.
  - With `tready` held high, the minimum interval is 3 cycles per byte.
  - A low `tready` stalls in RD_SEND indefinitely.
- `rfg_read` and `rfg_write` are never high together.
- `fifo_empty` stalls any consuming state without a state change.

## Configuration
- `RFG_PROTOCOL_TIMEOUT_EN`: when defined, an idle counter is cleared on every consumed byte or accepted beat, and counts while `busy`.
  - Reaching `TIMEOUT_CYCLES` pulses `protocol_error` and returns to HEADER; a pending response beat is dropped.
  - Without the macro there is no counter, and a partial frame waits forever.

## Structure
- Package `rfg_axis_protocol_pkg`: state enum `rfg_proto_state_t`; header bit indices `RFG_HDR_READ_BIT = 7` and `RFG_HDR_INCR_BIT = 6`; reserved mask `RFG_HDR_RSVD_MASK = 8'h3F`.
- Sub-module `rfg_axis_protocol_timeout`: idle counter with clear/enable inputs and an expiry pulse output. It is instantiated only under the macro.

## Test plan
- Write frame 0x40,0x10,0x00,0x02,AA,BB,CC → three `rfg_write` strobes on consecutive cycles: (0x10,AA), (0x11,BB), (0x12,CC). `busy` deasserts after the last.
- Read frame 0x80,0x20,0x00,0x01 with the register file returning 0x5A,0x6B and `tready`=1 → two `rfg_read` at address 0x20, beats 0x5A then 0x6B, `tlast` on 0x6B.
- Increment read at address 0xFF, length 0x0001 → reads at 0xFF then 0x00.
- Header 0x81 → `protocol_error` pulse, no strobes; a following valid frame decodes correctly.
- Read with `tready` low for 10 cycles → `tdata` and `tvalid` held, no further `rfg_read` until the beat is accepted.
- With `RFG_PROTOCOL_TIMEOUT_EN`, stop after the address byte for `TIMEOUT_CYCLES` → error pulse, state HEADER. Also assert `resn` low mid-write → all outputs 0, no write strobe.
